led_pwm_driver: RTL and testbench

Output-side counterpart to the button input path. It takes a 6-bit LED pattern and a brightness from core logic through a load/ready handshake and drives the board LEDs with registered, glitch-free PWM. An optional blink gate is included. It sits between the top-level counter/display logic and the `led` pins.

---
 rtl/led_pkg.sv | 15 +
 rtl/led_pwm_driver_if.sv | 14 +
 rtl/pwm_timebase.sv | 30 +++
 rtl/led_pwm_driver.sv | 94 +++++++++
 tb/tb_led_pwm_driver.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared constants and the pattern/duty record for the LED PWM driver.
package led_pkg;
  localparam int LED_COUNT        = 6;
  localparam int DEF_PWM_BITS     = 4;
  localparam int DEF_PRESCALE     = 64;
  localparam int DEF_BLINK_TICKS  = 13500000;
  // The duty field is sized for the widest supported PWM counter. Narrower
  // builds zero-extend into it, so one record type serves every PWM_BITS.
  localparam int DUTY_W_MAX       = 8;

  typedef struct packed {
    logic [LED_COUNT-1:0]  pattern;
    logic [DUTY_W_MAX-1:0] duty;
  } led_cfg_t;
endpackage

// File: rtl/led_pwm_driver_if.sv
// Core-side load/ready bus of the LED PWM driver, plus the LED pins.
interface led_pwm_driver_if #(parameter int PWM_BITS = 4);
  import led_pkg::*;

  logic [LED_COUNT-1:0] value;
  logic [PWM_BITS-1:0]  duty;
  logic                 load;
  logic                 ready;
  logic                 blink;
  logic [LED_COUNT-1:0] led;

  modport master (output value, duty, load, blink, input ready, led);
  modport slave  (input value, duty, load, blink, output ready, led);
endinterface

// File: rtl/pwm_timebase.sv
// Prescaler plus PWM counter. Produces a one-cycle tick every PRESCALE
// clocks and a period_start strobe on the last tick of each PWM period.
module pwm_timebase #(
  parameter int PRESCALE = 64,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                tick,
  output logic                period_start,
  output logic [PWM_BITS-1:0] pwm_cnt
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] prescaler;

  assign tick         = (prescaler == PS_W'(PRESCALE - 1));
  assign period_start = tick && (pwm_cnt == '1);

  // Prescaler wraps at PRESCALE-1; PWM counter advances on tick and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_pwm_driver.sv
// LED PWM driver: captures pattern+brightness through a load/ready
// handshake into a shadow register, swaps it in at a PWM period boundary
// so a period never mixes old and new data, and drives registered PWM.
// Optional blink gate: define LED_PWM_BLINK_EN.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int PRESCALE    = DEF_PRESCALE,
  parameter int PWM_BITS    = DEF_PWM_BITS,
  parameter int BLINK_TICKS = DEF_BLINK_TICKS,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  led_pwm_driver_if.slave  bus
);
  if (PRESCALE < 1 || BLINK_TICKS < 1 || PWM_BITS < 1 || PWM_BITS > DUTY_W_MAX) begin : g_bad_cfg
    $error("led_pwm_driver: unsupported parameter combination");
  end

  logic                 tick, period_start;
  logic [PWM_BITS-1:0]  pwm_cnt;
  led_cfg_t             shadow, active;
  logic                 pending;
  logic                 apply, accept;
  logic                 on, gate;
  logic [LED_COUNT-1:0] led_next, led_q;

  pwm_timebase #(.PRESCALE(PRESCALE), .PWM_BITS(PWM_BITS)) u_timebase (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .period_start (period_start),
    .pwm_cnt      (pwm_cnt)
  );

  assign bus.ready = !pending;
  // Apply wins over accept: while pending, ready is low so a load is ignored.
  assign apply     = tick && period_start && pending;
  assign accept    = bus.load && !pending;

  // Shadow capture on accept; shadow -> active only at a period boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (apply) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (accept) begin
      shadow.pattern <= bus.value;
      shadow.duty    <= DUTY_W_MAX'(bus.duty);
      pending        <= 1'b1;
    end
  end

  // All-ones duty is a true 100%; otherwise the last count of the period would be dark.
  assign on = (active.duty == DUTY_W_MAX'({PWM_BITS{1'b1}})) ||
              (DUTY_W_MAX'(pwm_cnt) < active.duty);

`ifdef LED_PWM_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  // Free-running blink half-period counter; phase flips at terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign gate = bus.blink ? phase : 1'b1;
`else
  assign gate = 1'b1;
`endif

  assign led_next = active.pattern & {LED_COUNT{on & gate}};

  // Output register keeps the pins glitch-free; reset forces all LEDs dark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) led_q <= {LED_COUNT{ACTIVE_LOW}};
    else       led_q <= ACTIVE_LOW ? ~led_next : led_next;
  end

  assign bus.led = led_q;
endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver (PRESCALE=2, PWM_BITS=2, BLINK_TICKS=20, active-low).
// Reference: the timebase is derived arithmetically from the cycle count
// since reset; handshake state is tracked at transaction level.
module tb_led_pwm_driver;
  localparam int P  = 2;
  localparam int B  = 2;
  localparam int BT = 20;
  localparam int PERIOD = P * (1 << B);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  led_pwm_driver_if #(.PWM_BITS(B)) bus ();

  led_pwm_driver #(.PRESCALE(P), .PWM_BITS(B), .BLINK_TICKS(BT), .ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  int         m_n;
  logic       m_pending;
  logic [5:0] m_sv, m_av;
  logic [1:0] m_sd, m_ad;
  logic [5:0] m_led;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_led(input int n, input logic [5:0] v,
                                         input logic [1:0] d, input logic bl);
    int  pwm;
    bit  on_b;
    bit  g;
    pwm  = (n / P) % (1 << B);
    on_b = (d == 2'd3) || (pwm < int'(d));
    g    = 1'b1;
`ifdef LED_PWM_BLINK_EN
    if (bl) g = ((n / BT) % 2) == 0;
`else
    if (bl) g = 1'b1;
`endif
    return ~(v & {6{on_b && g}});
  endfunction

  // Reference model: period_start is the last cycle of each PERIOD-cycle frame.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_n <= 0; m_pending <= 1'b0;
      m_sv <= '0; m_sd <= '0; m_av <= '0; m_ad <= '0;
      m_led <= 6'h3f;
    end else begin
      m_n   <= m_n + 1;
      m_led <= exp_led(m_n, m_av, m_ad, bus.blink);
      if ((m_n % PERIOD) == PERIOD - 1 && m_pending) begin
        m_av <= m_sv; m_ad <= m_sd; m_pending <= 1'b0;
      end else if (bus.load && !m_pending) begin
        m_sv <= bus.value; m_sd <= bus.duty; m_pending <= 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("led", 32'(bus.led), 32'(m_led));
      check("ready", 32'(bus.ready), 32'(!m_pending));
    end
  end

  task automatic do_load(input logic [5:0] v, input logic [1:0] d);
    bus.value = v; bus.duty = d; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!bus.ready && k < 4 * PERIOD) begin
      @(negedge clk); k++;
    end
    check(name, 32'(bus.ready), 32'd1);
  endtask

  // Counts cycles (over n) where led equals pat.
  task automatic count_led(input int n, input logic [5:0] pat, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.led == pat) hits++;
      @(negedge clk);
    end
  endtask

  initial begin
    int hits, k;
    bus.value = '0; bus.duty = '0; bus.load = 1'b0; bus.blink = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("reset_led", 32'(bus.led), 32'h3f);
    check("reset_ready", 32'(bus.ready), 32'd1);
    chk_en = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 50% duty on LEDs 0 and 2.
    do_load(6'b000101, 2'd2);
    check("ready_drop", 32'(bus.ready), 32'd0);
    wait_ready("apply_d2");
    @(negedge clk);
    count_led(PERIOD, 6'b111010, hits);
    check("d2_lit", 32'(hits), 32'd4);
    count_led(PERIOD, 6'b111111, hits);
    check("d2_dark", 32'(hits), 32'd4);

    // Full and zero duty.
    do_load(6'b000101, 2'd3);
    wait_ready("apply_d3");
    @(negedge clk);
    count_led(PERIOD, 6'b111010, hits);
    check("d3_lit", 32'(hits), 32'(PERIOD));
    do_load(6'b000101, 2'd0);
    wait_ready("apply_d0");
    @(negedge clk);
    count_led(PERIOD, 6'b111111, hits);
    check("d0_dark", 32'(hits), 32'(PERIOD));

    // Load while pending is ignored.
    do_load(6'b000101, 2'd3);
    do_load(6'b111111, 2'd3);
    wait_ready("apply_first");
    @(negedge clk);
    count_led(PERIOD, 6'b111010, hits);
    check("ignored_load", 32'(hits), 32'(PERIOD));

    // Load coincident with period_start waits one full period.
    k = 0;
    while ((m_n % PERIOD) != PERIOD - 1 && k < 2 * PERIOD) begin
      @(negedge clk); k++;
    end
    check("found_ps", 32'(m_n % PERIOD), 32'(PERIOD - 1));
    do_load(6'b110000, 2'd3);
    k = 0; hits = 0;
    while (!bus.ready && k < 4 * PERIOD) begin
      if (bus.led == 6'b111010) hits++;
      k++;
      @(negedge clk);
    end
    check("ps_load_wait", 32'(k), 32'(PERIOD));
    check("ps_load_old", 32'(hits), 32'(PERIOD));
    @(negedge clk);
    check("ps_load_new", 32'(bus.led), 32'h0f);

    // Mid-run reset with a load pending.
    do_load(6'b000011, 2'd3);
    #2 reset = 1'b1;
    #1;
    check("midreset_led", 32'(bus.led), 32'h3f);
    check("midreset_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    count_led(2 * PERIOD, 6'b111111, hits);
    check("midreset_dark", 32'(hits), 32'(2 * PERIOD));

    // Blink gate.
    do_load(6'b000101, 2'd3);
    wait_ready("apply_blink");
    @(negedge clk);
    bus.blink = 1'b1;
    @(negedge clk);
    count_led(2 * BT, 6'b111010, hits);
`ifdef LED_PWM_BLINK_EN
    check("blink_lit", 32'(hits), 32'(BT));
`else
    check("blink_ignored", 32'(hits), 32'(2 * BT));
`endif
    bus.blink = 1'b0;
    @(negedge clk);
    count_led(2 * BT, 6'b111010, hits);
    check("blink_off", 32'(hits), 32'(2 * BT));

    // Randomized stream, including one mid-run reset.
    for (int i = 0; i < 800; i++) begin
      bus.load  = ($urandom % 4) == 0;
      bus.value = 6'($urandom);
      bus.duty  = 2'($urandom);
      if (i % 50 == 0) bus.blink = 1'($urandom);
      if (i == 400) begin
        #3 reset = 1'b1;
        #1 check("rand_reset_led", 32'(bus.led), 32'h3f);
      end
      @(negedge clk);
      if (i == 400) reset = 1'b0;
    end
    bus.load = 1'b0;
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
